// File: rtl/fq_pkg.sv
// Shared constants, FSM state enum and ball direction type for the fakequidditch ball engine.
package fq_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int V_VISIBLE    = 480;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE1_X    = 16;
  localparam int PADDLE2_X    = 616;
  localparam int DX0          = 2;
  localparam int DY           = 1;
  localparam int MAX_DX       = 6;
  localparam int PAUSE_FRAMES = 60;
  localparam int WIN_SCORE    = 5;

  localparam logic [9:0] CENTER_X = 10'((H_VISIBLE - BALL_SIZE) / 2);
  localparam logic [9:0] CENTER_Y = 10'((V_VISIBLE - BALL_SIZE) / 2);

  typedef enum logic [1:0] {SERVE, PLAY, GOAL, OVER} fq_state_e;

  typedef struct packed {
    logic right;
    logic down;
  } fq_dir_t;

endpackage

// File: rtl/fq_collide.sv
// Combinational ball step: moves the ball one frame and resolves wall bounces,
// paddle deflections and goal detection.
module fq_collide
  import fq_pkg::*;
(
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  fq_dir_t    i_dir,
  input  logic [2:0] i_dx,
  input  logic [9:0] i_team1_ver_pos,
  input  logic [9:0] i_team2_ver_pos,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output fq_dir_t    o_dir,
  output logic       o_paddle_hit,
  output logic       o_goal_left,
  output logic       o_goal_right
);

  localparam logic signed [10:0] L_EDGE = 11'(PADDLE1_X + PADDLE_W);
  localparam logic signed [10:0] R_EDGE = 11'(PADDLE2_X);
  localparam logic signed [10:0] BOT_Y  = 11'(V_VISIBLE - BALL_SIZE);
  localparam logic signed [10:0] BSZ    = 11'(BALL_SIZE);
  localparam logic signed [10:0] X_LIM  = 11'(H_VISIBLE);
  localparam logic signed [10:0] DY_S   = 11'(DY);
  localparam logic signed [10:0] ZERO   = 11'sd0;

  logic signed [10:0] w_x, w_y, w_dx, w_nx, w_ny;
  logic [11:0] w_y_u, w_p1_u, w_p2_u;
  logic w_ovl1, w_ovl2, w_hit_l, w_hit_r;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_dx = {8'b0, i_dx};
  assign w_nx = i_dir.right ? (w_x + w_dx) : (w_x - w_dx);
  assign w_ny = i_dir.down  ? (w_y + DY_S) : (w_y - DY_S);

  // Overlap uses the pre-move row; 12 bits since paddle rows are not clipped
  assign w_y_u  = {2'b0, i_y};
  assign w_p1_u = {2'b0, i_team1_ver_pos};
  assign w_p2_u = {2'b0, i_team2_ver_pos};
  assign w_ovl1 = (w_y_u + 12'(BALL_SIZE) > w_p1_u) && (w_y_u < w_p1_u + 12'(PADDLE_H));
  assign w_ovl2 = (w_y_u + 12'(BALL_SIZE) > w_p2_u) && (w_y_u < w_p2_u + 12'(PADDLE_H));

  assign w_hit_l = !i_dir.right && (w_nx <= L_EDGE) && (w_x >= L_EDGE) && w_ovl1;
  assign w_hit_r = i_dir.right && (w_nx + BSZ >= R_EDGE) && (w_x + BSZ <= R_EDGE) && w_ovl2;

  assign o_paddle_hit = w_hit_l || w_hit_r;
  assign o_goal_left  = !o_paddle_hit && (w_nx < ZERO);
  assign o_goal_right = !o_paddle_hit && (w_nx + BSZ > X_LIM);

  always_comb begin
    o_x   = w_nx[9:0];
    o_y   = w_ny[9:0];
    o_dir = i_dir;
    if (w_ny <= ZERO) begin
      o_y       = 10'd0;
      o_dir.down = 1'b1;
    end else if (w_ny >= BOT_Y) begin
      o_y       = 10'(V_VISIBLE - BALL_SIZE);
      o_dir.down = 1'b0;
    end
    if (w_hit_l) begin
      o_x        = 10'(PADDLE1_X + PADDLE_W);
      o_dir.right = 1'b1;
    end else if (w_hit_r) begin
      o_x        = 10'(PADDLE2_X - BALL_SIZE);
      o_dir.right = 1'b0;
    end
  end

endmodule

// File: rtl/fq_ball_controller.sv
// Quaffle motion and scoring engine: serve/play/goal/over FSM advanced once per frame_tick.
// Optional feature: define BALL_SPEEDUP_EN to speed the ball up on every paddle hit.
module fq_ball_controller
  import fq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_serve,
  input  logic [9:0] i_team1_ver_pos,
  input  logic [9:0] i_team2_ver_pos,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [3:0] o_score1,
  output logic [3:0] o_score2,
  output logic       o_goal,
  output logic       o_game_over
);

  fq_state_e  r_state, w_state_next;
  logic [9:0] r_x, r_y, w_x_next, w_y_next;
  fq_dir_t    r_dir, w_dir_next;
  logic [2:0] r_dx, w_dx_next, w_dx_bumped;
  logic [3:0] r_score1, r_score2, w_score1_next, w_score2_next;
  logic [5:0] r_pause, w_pause_next;
  logic       r_goal, w_goal_next, r_game_over, w_game_over_next;

  logic [9:0] w_c_x, w_c_y;
  fq_dir_t    w_c_dir;
  logic       w_c_hit, w_c_goal_l, w_c_goal_r;

  fq_collide u_collide (
    .i_x             (r_x),
    .i_y             (r_y),
    .i_dir           (r_dir),
    .i_dx            (r_dx),
    .i_team1_ver_pos (i_team1_ver_pos),
    .i_team2_ver_pos (i_team2_ver_pos),
    .o_x             (w_c_x),
    .o_y             (w_c_y),
    .o_dir           (w_c_dir),
    .o_paddle_hit    (w_c_hit),
    .o_goal_left     (w_c_goal_l),
    .o_goal_right    (w_c_goal_r)
  );

`ifdef BALL_SPEEDUP_EN
  assign w_dx_bumped = (r_dx >= 3'(MAX_DX)) ? 3'(MAX_DX) : r_dx + 3'd1;
`else
  assign w_dx_bumped = r_dx;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= SERVE;
      r_x         <= CENTER_X;
      r_y         <= CENTER_Y;
      r_dir       <= '{right: 1'b1, down: 1'b1};
      r_dx        <= 3'(DX0);
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_pause     <= 6'd0;
      r_goal      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_dir       <= w_dir_next;
      r_dx        <= w_dx_next;
      r_score1    <= w_score1_next;
      r_score2    <= w_score2_next;
      r_pause     <= w_pause_next;
      r_goal      <= w_goal_next;
      r_game_over <= w_game_over_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_dir_next    = r_dir;
    w_dx_next     = r_dx;
    w_score1_next = r_score1;
    w_score2_next = r_score2;
    w_pause_next  = r_pause;
    w_goal_next   = 1'b0;
    if (i_frame_tick) begin
      case (r_state)
        SERVE: begin
          w_x_next = CENTER_X;
          w_y_next = CENTER_Y;
          if (i_serve) w_state_next = PLAY;
        end
        PLAY: begin
          if (w_c_goal_l || w_c_goal_r) begin
            w_goal_next  = 1'b1;
            w_state_next = GOAL;
            w_pause_next = 6'd0;
            if (w_c_goal_r && r_score1 < 4'(WIN_SCORE)) w_score1_next = r_score1 + 4'd1;
            if (w_c_goal_l && r_score2 < 4'(WIN_SCORE)) w_score2_next = r_score2 + 4'd1;
          end else begin
            w_x_next   = w_c_x;
            w_y_next   = w_c_y;
            w_dir_next = w_c_dir;
            if (w_c_hit) w_dx_next = w_dx_bumped;
          end
        end
        GOAL: begin
          // Horizontal direction is still the scoring one, i.e. toward the conceding team
          if (r_pause == 6'(PAUSE_FRAMES - 1)) begin
            w_pause_next    = 6'd0;
            w_x_next        = CENTER_X;
            w_y_next        = CENTER_Y;
            w_dir_next.down = 1'b1;
            w_dx_next       = 3'(DX0);
            w_state_next    = (r_score1 == 4'(WIN_SCORE) || r_score2 == 4'(WIN_SCORE)) ? OVER : SERVE;
          end else begin
            w_pause_next = r_pause + 6'd1;
          end
        end
        OVER: begin
          w_x_next = CENTER_X;
          w_y_next = CENTER_Y;
          if (i_serve) begin
            w_score1_next = 4'd0;
            w_score2_next = 4'd0;
            w_dx_next     = 3'(DX0);
            w_state_next  = SERVE;
          end
        end
        default: w_state_next = SERVE;
      endcase
    end
    w_game_over_next = (w_state_next == OVER);
  end

  assign o_ball_x    = r_x;
  assign o_ball_y    = r_y;
  assign o_score1    = r_score1;
  assign o_score2    = r_score2;
  assign o_goal      = r_goal;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_fq_ball_controller.sv
// Random-stimulus scoreboard bench for fq_ball_controller against a velocity-based game model.
module tb_fq_ball_controller;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_GOAL  = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] p1 = 10'd0;
  logic [9:0] p2 = 10'd0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score1, score2;
  logic       goal, game_over;

  always #5 clk = ~clk;

  fq_ball_controller dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_frame_tick    (frame_tick),
    .i_serve         (serve),
    .i_team1_ver_pos (p1),
    .i_team2_ver_pos (p2),
    .o_ball_x        (ball_x),
    .o_ball_y        (ball_y),
    .o_score1        (score1),
    .o_score2        (score2),
    .o_goal          (goal),
    .o_game_over     (game_over)
  );

  typedef struct {
    int x;
    int y;
    int s1;
    int s2;
    int goal;
    int over;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   probeCount = 0;
  int   probeSeen = 0;
  bit   checkGoalLow = 1'b0;
  logic tickAtEdge = 1'b0;

  int mMode, mx, my, mvx, mvy, ms1, ms2, mPause, mLastScorer, overs;

  always @(posedge clk) tickAtEdge <= frame_tick;

  task automatic checkOutput(input string name, input int act, input int req);
    testsRun++;
    if (act != req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic compareEntry(input string tag, input exp_t e);
    checkOutput({tag, ".ball_x"}, int'(ball_x), e.x);
    checkOutput({tag, ".ball_y"}, int'(ball_y), e.y);
    checkOutput({tag, ".score1"}, int'(score1), e.s1);
    checkOutput({tag, ".score2"}, int'(score2), e.s2);
    checkOutput({tag, ".goal"}, int'(goal), e.goal);
    checkOutput({tag, ".game_over"}, int'(game_over), e.over);
  endtask

  // Monitor: pops one expectation per tick response, plus reset probes
  always begin : monitor
    exp_t e;
    @(negedge clk or probeCount);
    if (probeCount != probeSeen) begin
      probeSeen = probeCount;
      if (expQ.size() == 0) checkOutput("reset_underflow", 0, 1);
      else begin
        e = expQ.pop_front();
        compareEntry("reset", e);
      end
    end else begin
      if (checkGoalLow) checkOutput("goal_width", int'(goal), 0);
      checkGoalLow = 1'b0;
      if (tickAtEdge) begin
        if (expQ.size() == 0) checkOutput("tick_underflow", 0, 1);
        else begin
          e = expQ.pop_front();
          compareEntry("tick", e);
          checkGoalLow = (e.goal != 0);
        end
      end
    end
  end

  task automatic modelReset();
    mMode = M_SERVE; mx = 316; my = 236; mvx = 2; mvy = 1;
    ms1 = 0; ms2 = 0; mPause = 0; mLastScorer = 1;
  endtask

  task automatic modelStep(input bit srv, input int a, input int b, output exp_t e);
    int nx, ny, tx, ty, nvx, nvy, mag;
    bit hit;
    e.goal = 0;
    case (mMode)
      M_SERVE: begin
        mx = 316; my = 236;
        if (srv) mMode = M_PLAY;
      end
      M_PLAY: begin
        nx = mx + mvx; ny = my + mvy;
        tx = nx; ty = ny; nvx = mvx; nvy = mvy; hit = 1'b0;
        if (ny <= 0) begin ty = 0; nvy = 1; end
        else if (ny >= 472) begin ty = 472; nvy = -1; end
        mag = (mvx < 0) ? -mvx : mvx;
`ifdef BALL_SPEEDUP_EN
        if (mag < 6) mag++;
`endif
        if (mvx < 0 && nx <= 24 && mx >= 24 && my + 8 > a && my < a + 64) begin
          hit = 1'b1; tx = 24; nvx = mag;
        end else if (mvx > 0 && nx + 8 >= 616 && mx + 8 <= 616 && my + 8 > b && my < b + 64) begin
          hit = 1'b1; tx = 608; nvx = -mag;
        end
        if (!hit && (nx < 0 || nx + 8 > 640)) begin
          e.goal = 1;
          if (nx < 0) begin if (ms2 < 5) ms2++; mLastScorer = 2; end
          else begin if (ms1 < 5) ms1++; mLastScorer = 1; end
          mMode = M_GOAL; mPause = 0;
        end else begin
          mx = tx; my = ty; mvx = nvx; mvy = nvy;
        end
      end
      M_GOAL: begin
        mPause++;
        if (mPause == 60) begin
          mx = 316; my = 236; mvy = 1;
          mvx = (mLastScorer == 1) ? 2 : -2;
          if (ms1 == 5 || ms2 == 5) begin mMode = M_OVER; overs++; end
          else mMode = M_SERVE;
        end
      end
      default: begin
        if (srv) begin
          ms1 = 0; ms2 = 0; mMode = M_SERVE;
          mvx = (mvx < 0) ? -2 : 2;
        end
      end
    endcase
    e.x = mx; e.y = my; e.s1 = ms1; e.s2 = ms2;
    e.over = (mMode == M_OVER) ? 1 : 0;
  endtask

  task automatic applyReset();
    exp_t e;
    @(negedge clk);
    #2 rst_n = 1'b0;
    e = '{x: 316, y: 236, s1: 0, s2: 0, goal: 0, over: 0};
    expQ.push_back(e);
    #1 probeCount++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic applyStimulus(input bit srv, input logic [9:0] a, input logic [9:0] b);
    exp_t e;
    @(negedge clk);
    serve = srv; p1 = a; p2 = b;
    frame_tick = 1'b1;
    modelStep(srv, int'(a), int'(b), e);
    expQ.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  function automatic logic [9:0] pickPaddle();
    if ($urandom_range(0, 9) < 6) return (my >= 28) ? 10'(my - 28) : 10'd0;
    return 10'($urandom_range(0, 1023));
  endfunction

  initial begin
    overs = 0;
    modelReset();
    applyReset();
    for (int t = 0; t < 6000 && overs < 2; t++) begin
      if (t == 300) applyReset();
      applyStimulus($urandom_range(0, 2) == 0, pickPaddle(), pickPaddle());
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
